// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_serial_tx slice.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Wide enough to hold WIDTH+1 (parity frame) without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Clearable, enable-gated bit counter; terminal flags the frame's final bit.
module piso_bit_counter #(
  parameter int CNT_W = 4,
  parameter int LAST  = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign terminal = (count_reg == CNT_W'(LAST));

endmodule

// File: rtl/piso_serial_tx.sv
// LSB-first parallel-in/serial-out transmitter with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serial_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  state_t           state_reg;
  logic             load_ready_reg;
  logic             ser_valid_reg;
  logic [FRAME-1:0] shreg_reg;
  logic [FRAME-1:0] shreg_next;
  logic [FRAME-1:0] load_word;
  logic             load_fire;
  logic             beat;
  logic             last_bit;

`ifdef PISO_PARITY_EN
  // Parity rides in the top shift-register bit so it leaves after the data.
  assign load_word = {^load_data, load_data};
`else
  assign load_word = load_data;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < FRAME - 1; gi++) begin : g_shift
      assign shreg_next[gi] = shreg_reg[gi+1];
    end
  endgenerate
  assign shreg_next[FRAME-1] = 1'b0;

  assign load_fire = load_ready_reg & load_valid;
  assign beat      = ser_valid_reg & ser_ready;

  piso_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (FRAME - 1)
  ) u_bit_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (load_fire | (beat & last_bit)),
    .enable   (beat & ~last_bit),
    .terminal (last_bit)
  );

  // The last beat also shifts, leaving shreg all-zero so ser_out idles low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      load_ready_reg <= 1'b1;
      ser_valid_reg  <= 1'b0;
      shreg_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_valid) begin
            state_reg      <= SHIFT;
            load_ready_reg <= 1'b0;
            ser_valid_reg  <= 1'b1;
            shreg_reg      <= load_word;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            shreg_reg <= shreg_next;
            if (last_bit) begin
              state_reg      <= IDLE;
              load_ready_reg <= 1'b1;
              ser_valid_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg      <= IDLE;
          load_ready_reg <= 1'b1;
          ser_valid_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = load_ready_reg;
  assign busy       = ~load_ready_reg;
  assign ser_valid  = ser_valid_reg;
  assign ser_out    = shreg_reg[0];
  assign ser_last   = last_bit;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: directed frames plus randomized traffic.
module tb_piso_serial_tx;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] load_data = '0;
  logic             ser_ready = 1'b1;
  logic             ser_valid;
  logic             ser_out;
  logic             ser_last;
  logic             busy;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: driven by main

  piso_serial_tx #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .ser_ready  (ser_ready),
    .ser_valid  (ser_valid),
    .ser_out    (ser_out),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: data bits LSB first, then optional even parity; last flag on final bit.
  task automatic push_frame(input logic [WIDTH-1:0] d);
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      e.b    = (i < WIDTH) ? ((d >> i) & 1) : (^d);
      e.last = (i == FRAME - 1);
      q.push_back(e);
    end
    $display("load %02h accepted at %0t", d, $time);
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    load_valid = 1'b1;
    load_data  = d;
    n = 0;
    while (!load_ready && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    if (!load_ready) begin
      chk("load_timeout", 0, 1);
      load_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      push_frame(d);
      load_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clock); #1;
      if (ready_mode == 0) ser_ready = 1'b1;
      else if (ready_mode == 1) ser_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks handshake state against the model and pops on each beat.
  always @(negedge clock) begin
    if (reset) begin
      chk("load_ready", load_ready, q.size() == 0);
      chk("busy", busy, q.size() != 0);
      chk("ser_valid", ser_valid, q.size() != 0);
      if (ser_valid && q.size() != 0) begin
        chk("ser_out", ser_out, q[0].b);
        chk("ser_last", ser_last, q[0].last);
        if (ser_ready) begin
          $display("beat out=%0b last=%0b exp=%0b/%0b", ser_out, ser_last, q[0].b, q[0].last);
          void'(q.pop_front());
        end
      end else if (!ser_valid) begin
        chk("idle_out", {ser_out, ser_last}, 2'b00);
      end
    end
  end

  initial begin
    #12;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_outs", {ser_out, ser_last, busy}, 3'b000);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic frame
    send(8'hA5);
    wait_drain();
    @(posedge clock); #1;

    // Stall three cycles while bit 2 is presented
    ready_mode = 2;
    ser_ready  = 1'b1;
    send(8'h3C);
    repeat (2) begin @(posedge clock); #1; end
    ser_ready = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    ser_ready = 1'b1;
    wait_drain();
    ready_mode = 0;

    // Load attempt while busy must be ignored
    send(8'hFF);
    repeat (4) begin @(posedge clock); #1; end
    load_valid = 1'b1;
    load_data  = 8'h00;
    @(posedge clock); #1;
    load_valid = 1'b0;
    wait_drain();
    @(posedge clock); #1;

    // Asynchronous reset in the middle of a frame
    send(8'h81);
    repeat (3) begin @(posedge clock); #1; end
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_ser_valid", ser_valid, 0);
    chk("mid_rst_load_ready", load_ready, 1);
    chk("mid_rst_outs", {ser_out, ser_last, busy}, 3'b000);
    @(posedge clock); #1;
    reset = 1'b1;
    send(8'h01);
    wait_drain();

    // Back-to-back frames, one bubble between them
    send(8'h0F);
    send(8'hF0);
    wait_drain();

`ifdef PISO_PARITY_EN
    send(8'h07);
    wait_drain();
`endif

    // Randomized traffic with random receiver stalls
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(WIDTH'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    end
    wait_drain();
    ready_mode = 0;
    repeat (3) begin @(posedge clock); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
